// File: rtl/heartbeat_gen.sv
// Heartbeat animation for an N-digit 7-segment bank: bars move outward from the
// centre digit pair and are followed by rest steps. Runs continuously or as a one-shot.
module heartbeat_gen #(
  parameter int N_DIGITS   = 6,
  parameter int BASE_TICKS = 5_000_000,
  parameter int REST_STEPS = 2,
  parameter int RATE_W     = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  trig,
  input  logic [RATE_W-1:0]     rate_sel,
  output logic [8*N_DIGITS-1:0] seg,
  output logic                  beat_start,
  output logic                  busy
);

  localparam int M         = N_DIGITS / 2;
  localparam int T         = M + 1 + REST_STEPS;
  localparam int MAX_TICKS = BASE_TICKS * (2 ** RATE_W);
  localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int STEP_W    = (T > 1) ? $clog2(T) : 1;

  localparam logic [7:0] OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] LBAR = (ACTIVE_LOW != 0) ? 8'hCF : 8'h30;
  localparam logic [7:0] RBAR = (ACTIVE_LOW != 0) ? 8'hF9 : 8'h06;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nx;
  logic [STEP_W-1:0]     step, step_nx;
  logic [TICK_W-1:0]     tick, tick_nx, tick_last;
  logic [RATE_W-1:0]     rate_q, rate_nx;
  logic [8*N_DIGITS-1:0] seg_nx;

  // Step length is locked to the rate latched at the start of each beat.
  assign tick_last = TICK_W'(BASE_TICKS * (int'(rate_q) + 1) - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      tick   <= '0;
      rate_q <= '0;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      tick   <= tick_nx;
      rate_q <= rate_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    tick_nx  = tick;
    rate_nx  = rate_q;
    case (state)
      IDLE: begin
        if (en && (!mode || trig)) begin
          state_nx = RUN;
          step_nx  = '0;
          tick_nx  = '0;
          rate_nx  = rate_sel;
        end
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
          step_nx  = '0;
          tick_nx  = '0;
        end else if (tick == tick_last) begin
          tick_nx = '0;
          if (step == STEP_W'(T - 1)) begin
            step_nx = '0;
            if (mode) state_nx = IDLE;
            else      rate_nx  = rate_sel;
          end else begin
            step_nx = step + STEP_W'(1);
          end
        end else begin
          tick_nx = tick + TICK_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Step 0 puts the bars on the centre pair facing out; step 1 swaps them;
  // later active steps push the bars one digit further from the centre.
  always_comb begin
    seg_nx = {N_DIGITS{OFF}};
    if (state == RUN) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (step == '0) begin
          if (d == M)          seg_nx[8*d +: 8] = LBAR;
          else if (d == M - 1) seg_nx[8*d +: 8] = RBAR;
        end else if (step == STEP_W'(1)) begin
          if (d == M)          seg_nx[8*d +: 8] = RBAR;
          else if (d == M - 1) seg_nx[8*d +: 8] = LBAR;
        end else if (int'(step) <= M) begin
          if (d == M + int'(step) - 1) seg_nx[8*d +: 8] = RBAR;
          else if (d == M - int'(step)) seg_nx[8*d +: 8] = LBAR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= {N_DIGITS{OFF}};
      busy       <= 1'b0;
      beat_start <= 1'b0;
    end else begin
      seg        <= seg_nx;
      busy       <= (state == RUN);
      beat_start <= (state == RUN) && (step == '0) && (tick == '0);
    end
  end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Scoreboard bench for heartbeat_gen: a 6-digit instance with rest steps and an
// active-high 2-digit instance without rest, both on short 4-clock steps.
module tb_heartbeat_gen;

  typedef struct {
    int          cyc;
    logic [47:0] seg;
    logic        busy;
    logic        bs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, mode, trig;
  logic [1:0]  rate_sel;
  logic [47:0] seg_a;
  logic [15:0] seg_b;
  logic        bs_a, busy_a, bs_b, busy_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  heartbeat_gen #(.N_DIGITS(6), .BASE_TICKS(4), .REST_STEPS(2), .RATE_W(2), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig), .rate_sel(rate_sel),
    .seg(seg_a), .beat_start(bs_a), .busy(busy_a)
  );

  heartbeat_gen #(.N_DIGITS(2), .BASE_TICKS(4), .REST_STEPS(0), .RATE_W(2), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig), .rate_sel(rate_sel),
    .seg(seg_b), .beat_start(bs_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-derived frames for the 6-digit bank, bytes listed d5..d0.
  function automatic logic [47:0] pat6(input int k);
    case (k)
      0:       return 48'hFF_FF_CF_F9_FF_FF;
      1:       return 48'hFF_FF_F9_CF_FF_FF;
      2:       return 48'hFF_F9_FF_FF_CF_FF;
      3:       return 48'hF9_FF_FF_FF_FF_CF;
      default: return 48'hFF_FF_FF_FF_FF_FF;
    endcase
  endfunction

  function automatic logic [47:0] pat2(input int k);
    return (k == 0) ? 48'h3006 : 48'h0630;
  endfunction

  task automatic push_beat_a(input int c, input int len, input int n);
    for (int i = 0; i < n; i++) q_a.push_back('{c + i, pat6(i / len), 1'b1, i == 0});
  endtask

  task automatic push_idle_a(input int c, input int n);
    for (int i = 0; i < n; i++) q_a.push_back('{c + i, 48'hFF_FF_FF_FF_FF_FF, 1'b0, 1'b0});
  endtask

  task automatic push_beat_b(input int c, input int len, input int n);
    for (int i = 0; i < n; i++)
      q_b.push_back('{c + i, pat2((i / len) % 2), 1'b1, (i % (2 * len)) == 0});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input int c, input logic [47:0] act_seg,
                             input logic act_busy, input logic act_bs, input exp_t e);
    checks++;
    if (act_seg !== e.seg || act_busy !== e.busy || act_bs !== e.bs) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got seg=%h busy=%b beat_start=%b, expected seg=%h busy=%b beat_start=%b",
               name, c, act_seg, act_busy, act_bs, e.seg, e.busy, e.bs);
    end
  endtask

  // Monitor: each queued expectation is tagged with the cycle it belongs to.
  always @(negedge clk) begin
    while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      if (q_a[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL big_missed cycle %0d: expectation never compared, current cycle %0d",
                 q_a[0].cyc, cyc);
      end else begin
        checkOutput("big", cyc, seg_a, busy_a, bs_a, q_a[0]);
      end
      void'(q_a.pop_front());
    end
    while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      if (q_b[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL small_missed cycle %0d: expectation never compared, current cycle %0d",
                 q_b[0].cyc, cyc);
      end else begin
        checkOutput("small", cyc, {32'h0, seg_b}, busy_b, bs_b, q_b[0]);
      end
      void'(q_b.pop_front());
    end
  end

  task automatic applyStimulus();
    // Reset held with en and trig high: reset must win.
    rst = 1'b1; en = 1'b1; trig = 1'b1; mode = 1'b0; rate_sel = 2'd0;
    push_idle_a(1, 4);
    push_beat_a(5, 4, 24);
    for (int i = 1; i <= 4; i++) q_b.push_back('{i, 48'h0, 1'b0, 1'b0});
    push_beat_b(5, 4, 16);
    push_beat_b(21, 12, 24);
    wait_cyc(3);
    rst = 1'b0; trig = 1'b0;

    // Rate change mid-beat applies from the next beat only.
    wait_cyc(14);
    rate_sel = 2'd2;
    push_beat_a(29, 12, 72);
    wait_cyc(60);
    rate_sel = 2'd0;
    push_beat_a(101, 4, 10);
    push_idle_a(111, 5);

    // Enable dropped during step 2, then restored.
    wait_cyc(109);
    en = 1'b0;
    wait_cyc(114);
    en = 1'b1;
    push_beat_a(116, 4, 24);
    push_beat_a(140, 4, 13);
    push_idle_a(153, 4);

    // Reset during step 3.
    wait_cyc(152);
    rst = 1'b1;
    wait_cyc(155);
    rst = 1'b0;
    push_beat_a(157, 4, 24);

    // Switch to one-shot mid-beat: the current beat still completes.
    wait_cyc(160);
    mode = 1'b1;
    push_idle_a(181, 9);
    wait_cyc(188);
    trig = 1'b1;
    push_beat_a(190, 4, 24);
    push_idle_a(214, 17);
    wait_cyc(189);
    trig = 1'b0;
    wait_cyc(195);
    trig = 1'b1;
    wait_cyc(196);
    trig = 1'b0;
    wait_cyc(232);
  endtask

  initial begin
    applyStimulus();
    if (q_a.size() != 0 || q_b.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d/%0d expectations left, expected 0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
